// File: rtl/fifo_read_empty.sv
// -----------------------------------------------------------------------------
// fifo_read_empty
//
// Read-side pointer and status stage of an asynchronous FIFO (the mirror of the
// write-full stage). It owns the read pointer in binary and gray form, drives
// the RAM read address, and derives empty, almost-empty, fill level and a
// sticky underflow flag. These are derived from the write pointer, which has
// already been synchronised into this clock domain.
//
// Parameters
//   size       pointer width including the wrap bit. The address width is
//              size-1 and the depth is 2**(size-1).
//   AE_THRESH  raempty is set while the fill level is <= AE_THRESH (0..depth).
//
// Ports
//   clk       in   1       read-domain clock (the only clock)
//   rst_n     in   1       synchronous active-low reset
//   rinc      in   1       read request; pops one word when rempty=0
//   rq2_wptr  in   size    write gray pointer, synchronised into clk domain
//   clr_err   in   1       clears rerr (a new underflow in the same cycle wins)
//   raddr     out  size-1  RAM read address (low bits of the binary pointer)
//   rptr      out  size    registered read gray pointer, to the r->w synchroniser
//   rempty    out  1       registered empty flag
//   raempty   out  1       registered almost-empty flag
//   rlevel    out  size    registered count of readable words, 0..depth
//   rerr      out  1       sticky underflow flag
//
// rq2_wptr must be a valid gray code between 0 and depth entries ahead of the
// read pointer. Values outside that range give undefined status; no clamping
// is applied.
// -----------------------------------------------------------------------------
module fifo_read_empty #(
    parameter int size      = 8,
    parameter int AE_THRESH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rinc,
    input  logic [size-1:0] rq2_wptr,
    input  logic            clr_err,
    output logic [size-2:0] raddr,
    output logic [size-1:0] rptr,
    output logic            rempty,
    output logic            raempty,
    output logic [size-1:0] rlevel,
    output logic            rerr
);

    // Almost-empty threshold at pointer width for the level compare.
    localparam logic [size-1:0] AE_LIMIT = size'(AE_THRESH);

    // Gray code of a binary pointer.
    function automatic logic [size-1:0] bin2gray(input logic [size-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary value of a gray pointer: each bit is the XOR of all gray bits at
    // or above it.
    function automatic logic [size-1:0] gray2bin(input logic [size-1:0] g);
        logic [size-1:0] b;
        b[size-1] = g[size-1];
        for (int i = size - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // State registers
    logic [size-1:0] rbin_r;
    logic [size-1:0] rptr_r;
    logic            rempty_r;
    logic            raempty_r;
    logic [size-1:0] rlevel_r;
    logic            rerr_r;

    // Next-state values
    logic            pop_s;
    logic [size-1:0] rbin_next_s;
    logic [size-1:0] rgray_next_s;
    logic [size-1:0] wbin_s;
    logic [size-1:0] lvl_s;
    logic            rempty_next_s;
    logic            raempty_next_s;
    logic            rerr_next_s;

    // Next pointer and status. All flags are derived from the post-pop
    // pointer, so a pop and a write-pointer advance at the same edge both
    // count toward the level.
    always_comb begin
        pop_s          = rinc & ~rempty_r;
        rbin_next_s    = rbin_r + {{(size-1){1'b0}}, pop_s};
        rgray_next_s   = bin2gray(rbin_next_s);
        wbin_s         = gray2bin(rq2_wptr);
        lvl_s          = wbin_s - rbin_next_s;
        // A gray compare matches (lvl_s == 0) for in-contract pointers. It
        // avoids depending on the gray-to-binary chain for the empty flag.
        rempty_next_s  = (rgray_next_s == rq2_wptr);
        raempty_next_s = (lvl_s <= AE_LIMIT);
        // Underflow sets the flag; a set in the same cycle as a clear wins.
        if (rinc && rempty_r) begin
            rerr_next_s = 1'b1;
        end else if (clr_err) begin
            rerr_next_s = 1'b0;
        end else begin
            rerr_next_s = rerr_r;
        end
    end

    // Register the pointer and status. Reset overrides every input, including
    // an in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rbin_r    <= {size{1'b0}};
            rptr_r    <= {size{1'b0}};
            rempty_r  <= 1'b1;
            raempty_r <= 1'b1;
            rlevel_r  <= {size{1'b0}};
            rerr_r    <= 1'b0;
        end else begin
            rbin_r    <= rbin_next_s;
            rptr_r    <= rgray_next_s;
            rempty_r  <= rempty_next_s;
            raempty_r <= raempty_next_s;
            rlevel_r  <= lvl_s;
            rerr_r    <= rerr_next_s;
        end
    end

    // The RAM address comes directly from the binary register, so the word
    // being popped is addressed before the pop.
    assign raddr   = rbin_r[size-2:0];
    assign rptr    = rptr_r;
    assign rempty  = rempty_r;
    assign raempty = raempty_r;
    assign rlevel  = rlevel_r;
    assign rerr    = rerr_r;

endmodule

// File: tb/tb_fifo_read_empty.sv
module tb_fifo_read_empty;

    logic       clk;
    logic       rst_n;
    logic       rinc;
    logic [3:0] rq2_wptr;
    logic       clr_err;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [3:0] rlevel;
    logic       rerr;

    int n_total = 0;
    int n_bad   = 0;

    fifo_read_empty #(.size(4), .AE_THRESH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rinc     (rinc),
        .rq2_wptr (rq2_wptr),
        .clr_err  (clr_err),
        .raddr    (raddr),
        .rptr     (rptr),
        .rempty   (rempty),
        .raempty  (raempty),
        .rlevel   (rlevel),
        .rerr     (rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       ri;
        logic       ce;
        logic [3:0] w;
        logic [3:0] e_rptr;
        logic [2:0] e_raddr;
        logic       e_empty;
        logic       e_aempty;
        logic [3:0] e_level;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic add(input logic rn, input logic ri, input logic ce, input logic [3:0] w,
                       input logic [3:0] er, input logic [2:0] ea, input logic ee,
                       input logic eae, input logic [3:0] el, input logic eerr);
        vec_t v;
        v.rn = rn; v.ri = ri; v.ce = ce; v.w = w;
        v.e_rptr = er; v.e_raddr = ea; v.e_empty = ee; v.e_aempty = eae;
        v.e_level = el; v.e_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; rinc = 1'b0; clr_err = 1'b0; rq2_wptr = 4'b0000;

        // rn ri ce  w        rptr     raddr  e     ae    lvl    err
        // reset for two edges with rinc high and a non-zero write pointer
        add(1'b0, 1'b1, 1'b0, 4'b0110, 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 4'b0110, 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        // three words written, then three pops
        add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd3, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0010, 4'b0001, 3'd1, 1'b0, 1'b1, 4'd2, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0010, 4'b0011, 3'd2, 1'b0, 1'b1, 4'd1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0, 1'b0);
        // underflow: pointer holds, rerr sticky, set beats clear
        add(1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 4'b0010, 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010, 3'd3, 1'b1, 1'b1, 4'd0, 1'b0);
        // full FIFO from zero, drain 8, then another 8 with pointer wrap
        add(1'b0, 1'b0, 1'b0, 4'b1100, 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);
        for (int k = 1; k <= 8; k++)
            add(1'b1, 1'b1, 1'b0, 4'b1100, gray4(k), 3'(k % 8), (k == 8),
                ((8 - k) <= 2), 4'(8 - k), 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1100, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);
        for (int k = 9; k <= 16; k++)
            add(1'b1, 1'b1, 1'b0, 4'b0000, gray4(k % 16), 3'(k % 8), (k == 16),
                ((16 - k) <= 2), 4'(16 - k), 1'b0);
        // pop and write advance at the same edge: level stays 1
        add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0011, 4'b0001, 3'd1, 1'b0, 1'b1, 4'd1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0010, 4'b0011, 3'd2, 1'b0, 1'b1, 4'd1, 1'b0);
        // mid-operation reset with a read in flight
        add(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd7, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0100, 4'b0001, 3'd1, 1'b0, 1'b0, 4'd6, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0100, 4'b0011, 3'd2, 1'b0, 1'b0, 4'd5, 1'b0);
        add(1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd7, 1'b0);

        foreach (vecs[i]) begin
            rst_n    = vecs[i].rn;
            rinc     = vecs[i].ri;
            clr_err  = vecs[i].ce;
            rq2_wptr = vecs[i].w;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {18'd0, rptr, raddr, rempty, raempty, rlevel, rerr},
                  {18'd0, vecs[i].e_rptr, vecs[i].e_raddr, vecs[i].e_empty,
                   vecs[i].e_aempty, vecs[i].e_level, vecs[i].e_err});
        end

        // Drain the 7 remaining words with a bounded loop.
        rinc = 1'b1;
        n = 0;
        while (n < 16) begin
            @(posedge clk);
            #1;
            n++;
            if (rempty) break;
        end
        rinc = 1'b0;
        check("drain_count", 32'(n), 32'd7);
        check("drain_rptr", {28'd0, rptr}, {28'd0, gray4(7)});
        check("drain_no_err", {31'd0, rerr}, 32'd0);

        // A write-pointer change shows up on the registered flags only after an edge.
        rq2_wptr = 4'b1100;
        #2;
        check("empty_held", {31'd0, rempty}, 32'd1);
        @(posedge clk);
        #1;
        check("empty_clear", {31'd0, rempty}, 32'd0);
        check("level_one", {28'd0, rlevel}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
